// File: rtl/t07_bus_pkg.sv
// Shared encodings for the CPU-side Wishbone bridge: request codes, bridge
// states and the default data word returned after an aborted read.
package t07_bus_pkg;

  typedef enum logic [1:0] {
    RWI_IDLE  = 2'b00,
    RWI_STORE = 2'b01,
    RWI_LOAD  = 2'b10,
    RWI_FETCH = 2'b11
  } rwi_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_t;

  localparam logic [31:0] DEF_ERR_DATA = 32'hBAD0_BAD0;
  localparam logic [3:0]  SEL_WORD     = 4'hF;

endpackage

// File: rtl/t07_bus_watchdog.sv
// Saturating cycle counter for the REQ phase; expired_o flags the last
// permitted wait cycle so the abort lands TIMEOUT_CYCLES cycles after entry.
module t07_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && cnt_q != SAT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q counts completed REQ cycles, so LAST marks the final one
  assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/t07_mem_bus_bridge.sv
// Single-beat Wishbone-classic master for the CPU memory handler. Every IDLE
// sample of a non-idle rwi_i issues one transaction; DONE guarantees a gap.
module t07_mem_bus_bridge
  import t07_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rwi_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);
  bridge_state_t state_q, state_d;
  rwi_t          rwi;
  logic          expired;

  logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d, stb_q, stb_d, cyc_q, cyc_d;
  logic        busy_q, busy_d, err_q, err_d;

  assign rwi = rwi_t'(rwi_i);

  t07_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != ST_REQ),
    .en_i      (state_q == ST_REQ),
    .expired_o (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rwi != RWI_IDLE) state_d = ST_REQ;
      ST_REQ:  if (ACK_I || expired) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (rwi != RWI_IDLE) begin
          adr_d  = addr_i;
          dat_d  = wdata_i;
          we_d   = (rwi == RWI_STORE);
          sel_d  = SEL_WORD;
          stb_d  = 1'b1;
          cyc_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      ST_REQ: begin
        // ACK takes priority over a timeout landing on the same cycle
        if (ACK_I || expired) begin
          stb_d  = 1'b0;
          cyc_d  = 1'b0;
          we_d   = 1'b0;
          busy_d = 1'b0;
          if (ACK_I) begin
            if (!we_q) rdata_d = DAT_I;
          end else begin
            err_d = 1'b1;
            if (!we_q) rdata_d = ERR_DATA;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ADR_O   = adr_q;
  assign DAT_O   = dat_q;
  assign SEL_O   = sel_q;
  assign WE_O    = we_q;
  assign STB_O   = stb_q;
  assign CYC_O   = cyc_q;
  assign busy_o  = busy_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule
